// File: rtl/radix4_stage1_butterfly.sv
// radix4_stage1_butterfly: first radix-4 stage of the 16-point FFT.
// Takes x[n], x[n+4], x[n+8], x[n+12] per cycle, forms the four butterfly
// outputs scaled by 1/4, then rotates lane k by W16^(n*k).
// Pipeline: input register -> butterfly register -> twiddle/output register.
// Samples are {re[31:16], im[15:0]}, each signed Q1.15.
module radix4_stage1_butterfly (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sync,
  input  logic [31:0] in_0,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  input  logic [31:0] in_3,
  output logic        out_valid,
  output logic [1:0]  out_idx,
  output logic [31:0] out_0,
  output logic [31:0] out_1,
  output logic [31:0] out_2,
  output logic [31:0] out_3
);

  // Packed {c, s} for W = c - j*s, indexed by m = n*k (only 0,1,2,3,4,6,9 occur)
  function automatic logic [31:0] twiddle(input logic [3:0] m);
    case (m)
      4'd0:    twiddle = 32'h7FFF_0000;  //  32767,      0
      4'd1:    twiddle = 32'h7642_30FC;  //  30274,  12540
      4'd2:    twiddle = 32'h5A82_5A82;  //  23170,  23170
      4'd3:    twiddle = 32'h30FC_7642;  //  12540,  30274
      4'd4:    twiddle = 32'h0000_7FFF;  //      0,  32767
      4'd6:    twiddle = 32'hA57E_5A82;  // -23170,  23170
      4'd9:    twiddle = 32'h89BE_CF04;  // -30274, -12540
      default: twiddle = 32'h7FFF_0000;
    endcase
  endfunction

  // Shift right 15 (floor) then clamp into the 16-bit signed range
  function automatic logic [15:0] rnd_sat(input logic signed [33:0] v);
    logic signed [33:0] sh;
    sh = v >>> 15;
    if (sh > 34'sd32767)
      rnd_sat = 16'h7FFF;
    else if (sh < -34'sd32768)
      rnd_sat = 16'h8000;
    else
      rnd_sat = 16'(sh);
  endfunction

  logic [1:0]         n;
  logic [1:0]         n_cur;

  logic               s1_valid;
  logic [1:0]         s1_idx;
  logic [31:0]        s1_x [4];

  logic signed [17:0] x_re [4];
  logic signed [17:0] x_im [4];
  logic signed [17:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
  logic signed [17:0] y_re [4];
  logic signed [17:0] y_im [4];
  logic signed [15:0] sc_re [4];
  logic signed [15:0] sc_im [4];

  logic               s2_valid;
  logic [1:0]         s2_idx;
  logic signed [15:0] s2_re [4];
  logic signed [15:0] s2_im [4];

  logic [3:0]         m [4];
  logic [31:0]        tw [4];
  logic signed [15:0] c_tw [4];
  logic signed [15:0] s_tw [4];
  logic signed [31:0] p_rc [4];
  logic signed [31:0] p_is [4];
  logic signed [31:0] p_ic [4];
  logic signed [31:0] p_rs [4];
  logic signed [33:0] zr_sum [4];
  logic signed [33:0] zi_sum [4];
  logic [15:0]        zr [4];
  logic [15:0]        zi [4];

  // Index used by the group being accepted: sync restarts the frame at 0
  always_comb begin
    n_cur = in_sync ? 2'd0 : n;
  end

  // Group counter advances only on accepted groups, wrapping 3 -> 0
  always_ff @(posedge clk) begin
    if (reset)
      n <= '0;
    else if (in_valid)
      n <= n_cur + 2'd1;
  end

  // Stage 1: capture inputs and index; data holds across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      for (int unsigned i = 0; i < 4; i++) s1_x[i] <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_idx  <= n_cur;
        s1_x[0] <= in_0;
        s1_x[1] <= in_1;
        s1_x[2] <= in_2;
        s1_x[3] <= in_3;
      end
    end
  end

  // Butterfly at 18-bit width, then floor-shift by 2 back to 16 bits
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      x_re[i] = {{2{s1_x[i][31]}}, s1_x[i][31:16]};
      x_im[i] = {{2{s1_x[i][15]}}, s1_x[i][15:0]};
    end
    a_re = x_re[0] + x_re[2];
    a_im = x_im[0] + x_im[2];
    b_re = x_re[0] - x_re[2];
    b_im = x_im[0] - x_im[2];
    c_re = x_re[1] + x_re[3];
    c_im = x_im[1] + x_im[3];
    d_re = x_re[1] - x_re[3];
    d_im = x_im[1] - x_im[3];
    y_re[0] = a_re + c_re;
    y_im[0] = a_im + c_im;
    y_re[1] = b_re + d_im;
    y_im[1] = b_im - d_re;
    y_re[2] = a_re - c_re;
    y_im[2] = a_im - c_im;
    y_re[3] = b_re - d_im;
    y_im[3] = b_im + d_re;
    for (int unsigned k = 0; k < 4; k++) begin
      sc_re[k] = 16'(y_re[k] >>> 2);
      sc_im[k] = 16'(y_im[k] >>> 2);
    end
  end

  // Stage 2: register scaled butterfly outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        s2_re[k] <= '0;
        s2_im[k] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        for (int unsigned k = 0; k < 4; k++) begin
          s2_re[k] <= sc_re[k];
          s2_im[k] <= sc_im[k];
        end
      end
    end
  end

  // Twiddle rotation per lane: z = y * (c - j*s), rounded and saturated
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      m[k]      = {2'b00, s2_idx} * 4'(k);
      tw[k]     = twiddle(m[k]);
      c_tw[k]   = tw[k][31:16];
      s_tw[k]   = tw[k][15:0];
      p_rc[k]   = 32'(s2_re[k]) * 32'(c_tw[k]);
      p_is[k]   = 32'(s2_im[k]) * 32'(s_tw[k]);
      p_ic[k]   = 32'(s2_im[k]) * 32'(c_tw[k]);
      p_rs[k]   = 32'(s2_re[k]) * 32'(s_tw[k]);
      zr_sum[k] = 34'(p_rc[k]) + 34'(p_is[k]) + 34'sd16384;
      zi_sum[k] = 34'(p_ic[k]) - 34'(p_rs[k]) + 34'sd16384;
      zr[k]     = rnd_sat(zr_sum[k]);
      zi[k]     = rnd_sat(zi_sum[k]);
    end
  end

  // Stage 3: output register; holds last group during bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_0     <= '0;
      out_1     <= '0;
      out_2     <= '0;
      out_3     <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_idx <= s2_idx;
        out_0   <= {zr[0], zi[0]};
        out_1   <= {zr[1], zi[1]};
        out_2   <= {zr[2], zi[2]};
        out_3   <= {zr[3], zi[3]};
      end
    end
  end

endmodule

// File: tb/tb_radix4_stage1_butterfly.sv
// Directed bench for radix4_stage1_butterfly: reset, DC, impulse, twiddles,
// saturation, counter wrap, bubbles, sync and mid-frame reset.
module tb_radix4_stage1_butterfly;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_sync;
  logic [31:0] in_0, in_1, in_2, in_3;
  logic        out_valid;
  logic [1:0]  out_idx;
  logic [31:0] out_0, out_1, out_2, out_3;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  radix4_stage1_butterfly dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_0     (in_0),
    .in_1     (in_1),
    .in_2     (in_2),
    .in_3     (in_3),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .out_0    (out_0),
    .out_1    (out_1),
    .out_2    (out_2),
    .out_3    (out_3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    in_valid = v;
    in_sync  = s;
    in_0 = a;
    in_1 = b;
    in_2 = c;
    in_3 = d;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic chk_grp(input string tag, input logic [1:0] idx,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".out_0"}, out_0, e0);
    chk({tag, ".out_1"}, out_1, e1);
    chk({tag, ".out_2"}, out_2, e2);
    chk({tag, ".out_3"}, out_3, e3);
  endtask

  task automatic chk_lane0(input string tag, input logic v, input logic [1:0] idx,
                           input logic [31:0] e0);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".out_0"}, out_0, e0);
  endtask

  initial begin
    // Reset held for 2 cycles while random valid groups are offered
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sync  = 1'b0;
    in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom()), $urandom(), $urandom(), $urandom(), $urandom());
      chk(.tag("rst.valid"), .obs(32'(out_valid)), .exp(32'd0));
      chk(.tag("rst.idx"),   .obs(32'(out_idx)),   .exp(32'd0));
      chk(.tag("rst.out_0"), .obs(out_0), .exp(32'd0));
      chk(.tag("rst.out_1"), .obs(out_1), .exp(32'd0));
      chk(.tag("rst.out_2"), .obs(out_2), .exp(32'd0));
      chk(.tag("rst.out_3"), .obs(out_3), .exp(32'd0));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, $urandom(), $urandom(), $urandom(), $urandom());
      chk("post_rst.valid", 32'(out_valid), 32'd0);
      chk("post_rst.out_0", out_0, 32'd0);
      chk("post_rst.out_3", out_3, 32'd0);
    end

    // DC: every input (4000, 0)
    drive(1'b1, 1'b1, 32'h0FA0_0000, 32'h0FA0_0000, 32'h0FA0_0000, 32'h0FA0_0000);
    idle();
    idle();
    chk_grp("dc", 2'd0, 32'h0FA0_0000, 32'h0, 32'h0, 32'h0);
    idle();
    chk_lane0("dc_hold", 1'b0, 2'd0, 32'h0FA0_0000);

    // Impulse on x1 at n = 0
    drive(1'b1, 1'b1, 32'h0, 32'h0FA0_0000, 32'h0, 32'h0);
    idle();
    idle();
    chk_grp("imp", 2'd0, 32'h03E8_0000, 32'h0000_FC18, 32'hFC18_0000, 32'h0000_03E8);

    // Twiddles at n = 2 with y_k = (2048, 0) on every lane
    drive(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'h0, 32'h0);
    chk_grp("tw_g0", 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    idle();
    chk_grp("tw_g1", 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    idle();
    chk_grp("tw_n2", 2'd2, 32'h0800_0000, 32'h05A8_FA58, 32'h0000_F800, 32'hFA58_FA58);

    // Saturation at n = 1: y2 = (-32768, -32768) rotated by W16^2
    drive(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_8000, 32'h7FFF_7FFF);
    idle();
    idle();
    chk_grp("sat", 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0);

    // Wrap 3 -> 0, and in_sync without in_valid must not restart the count
    drive(1'b1, 1'b1, 32'h0028_0000, 32'h0, 32'h0, 32'h0);  // v=10, n0
    drive(1'b1, 1'b0, 32'h0050_0000, 32'h0, 32'h0, 32'h0);  // v=20, n1
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);          // sync ignored
    chk_lane0("wrap_a", 1'b1, 2'd0, 32'h000A_0000);
    drive(1'b1, 1'b0, 32'h0078_0000, 32'h0, 32'h0, 32'h0);  // v=30, n2
    chk_lane0("wrap_b", 1'b1, 2'd1, 32'h0014_0000);
    drive(1'b1, 1'b0, 32'h00A0_0000, 32'h0, 32'h0, 32'h0);  // v=40, n3
    chk_lane0("wrap_bub", 1'b0, 2'd1, 32'h0014_0000);
    drive(1'b1, 1'b0, 32'h00C8_0000, 32'h0, 32'h0, 32'h0);  // v=50, n0
    chk_lane0("wrap_c", 1'b1, 2'd2, 32'h001E_0000);
    idle();
    chk_lane0("wrap_d", 1'b1, 2'd3, 32'h0028_0000);
    idle();
    chk_lane0("wrap_e", 1'b1, 2'd0, 32'h0032_0000);
    idle();

    // Bubbles: three groups, two idle cycles, then sync group and one more
    drive(1'b1, 1'b1, 32'h002C_0000, 32'h0, 32'h0, 32'h0);  // v=11
    drive(1'b1, 1'b0, 32'h0030_0000, 32'h0, 32'h0, 32'h0);  // v=12
    drive(1'b1, 1'b0, 32'h0034_0000, 32'h0, 32'h0, 32'h0);  // v=13
    chk_lane0("bub_g1", 1'b1, 2'd0, 32'h000B_0000);
    idle();
    chk_lane0("bub_g2", 1'b1, 2'd1, 32'h000C_0000);
    idle();
    chk_lane0("bub_g3", 1'b1, 2'd2, 32'h000D_0000);
    drive(1'b1, 1'b1, 32'h0038_0000, 32'h0, 32'h0, 32'h0);  // v=14, sync
    chk_lane0("bub_idle1", 1'b0, 2'd2, 32'h000D_0000);
    drive(1'b1, 1'b0, 32'h003C_0000, 32'h0, 32'h0, 32'h0);  // v=15
    chk_lane0("bub_idle2", 1'b0, 2'd2, 32'h000D_0000);
    idle();
    chk_lane0("bub_g4", 1'b1, 2'd0, 32'h000E_0000);
    idle();
    chk_lane0("bub_g5", 1'b1, 2'd1, 32'h000F_0000);
    idle();
    chk("bub_end.valid", 32'(out_valid), 32'd0);

    // Mid-frame reset one cycle after a group is accepted
    drive(1'b1, 1'b1, 32'h0054_0000, 32'h0, 32'h0, 32'h0);  // v=21
    drive(1'b1, 1'b0, 32'h0058_0000, 32'h0, 32'h0, 32'h0);  // v=22
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h018C_0000, 32'h0, 32'h0, 32'h0);  // dropped by reset
    reset = 1'b0;
    chk_lane0("mid_rst", 1'b0, 2'd0, 32'h0);
    idle();
    chk_lane0("mid_rst_d1", 1'b0, 2'd0, 32'h0);
    idle();
    chk_lane0("mid_rst_d2", 1'b0, 2'd0, 32'h0);
    drive(1'b1, 1'b0, 32'h005C_0000, 32'h0, 32'h0, 32'h0);  // v=23, no sync
    chk("mid_rst_d3.valid", 32'(out_valid), 32'd0);
    idle();
    idle();
    chk_lane0("mid_rst_next", 1'b1, 2'd0, 32'h0017_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
